// File: rtl/alarm_timer_sequencer_if.sv
// Avalon-MM link between the alarm sequencer (master) and the interval timer s1 port (slave).
interface alarm_timer_sequencer_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    modport master (output address, chipselect, write_n, writedata, input readdata, irq);
    modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/alarm_timer_sequencer.sv
// Sole Avalon-MM master of the interval timer: programs and starts it, services timeouts,
// keeps a wrapping tick count with a one-shot alarm, and performs counter snapshot reads.
module alarm_timer_sequencer #(
    parameter int          TICK_W         = 17,
    parameter int          TICK_WRAP      = 86400,
    parameter logic [31:0] DEFAULT_PERIOD = 32'd49999999
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start_i,
    input  logic                  cfg_stop_i,
    input  logic [31:0]           cfg_period_i,
    input  logic                  cfg_period_vld_i,
    input  logic [TICK_W-1:0]     alarm_tick_i,
    input  logic                  alarm_arm_i,
    input  logic                  alarm_ack_i,
    input  logic                  snap_req_i,
    alarm_timer_sequencer_if.master tmr,
    output logic                  running_o,
    output logic                  busy_o,
    output logic [TICK_W-1:0]     tick_count_o,
    output logic                  alarm_hit_o,
    output logic                  alarm_pending_o,
    output logic [31:0]           snap_value_o,
    output logic                  snap_valid_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTL, S_RUN, S_ACK, S_STOP,
        S_SNAP_W, S_SNAP_RL, S_SNAP_RH, S_SNAP_CAP
    } state_t;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_WRAP - 1);

    state_t              state_q, state_d;
    logic [31:0]         period_q, period_d;
    logic                running_q, running_d;
    logic [TICK_W-1:0]   tick_q, tick_d, tick_inc;
    logic [1:0]          block_q, block_d;
    logic                hit_q, hit_d;
    logic                pending_q, pending_d;
    logic [15:0]         snap_lo_q, snap_lo_d;
    logic [31:0]         snap_value_q, snap_value_d;
    logic                snap_valid_q, snap_valid_d;

    logic [2:0]          addr_c;
    logic                cs_c;
    logic                wn_c;
    logic [15:0]         wdata_c;

    assign tick_inc = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            period_q     <= DEFAULT_PERIOD;
            running_q    <= 1'b0;
            tick_q       <= '0;
            block_q      <= 2'd0;
            hit_q        <= 1'b0;
            pending_q    <= 1'b0;
            snap_lo_q    <= 16'h0;
            snap_value_q <= 32'h0;
            snap_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            running_q    <= running_d;
            tick_q       <= tick_d;
            block_q      <= block_d;
            hit_q        <= hit_d;
            pending_q    <= pending_d;
            snap_lo_q    <= snap_lo_d;
            snap_value_q <= snap_value_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        running_d    = running_q;
        tick_d       = tick_q;
        block_d      = (block_q != 2'd0) ? block_q - 2'd1 : 2'd0;
        hit_d        = 1'b0;
        // A hit in the same cycle as an ack wins, so the flag cannot be lost.
        pending_d    = hit_q | (pending_q & ~alarm_ack_i);
        snap_lo_d    = snap_lo_q;
        snap_value_d = snap_value_q;
        snap_valid_d = 1'b0;
        addr_c       = 3'd0;
        cs_c         = 1'b0;
        wn_c         = 1'b1;
        wdata_c      = 16'h0;

        case (state_q)
            S_IDLE: begin
                if (cfg_start_i) begin
                    period_d = cfg_period_vld_i ? cfg_period_i : DEFAULT_PERIOD;
                    state_d  = S_WR_PL;
                end else if (snap_req_i) begin
                    state_d  = S_SNAP_W;
                end
            end
            S_WR_PL: begin
                cs_c = 1'b1; wn_c = 1'b0; addr_c = 3'd2; wdata_c = period_q[15:0];
                state_d = S_WR_PH;
            end
            S_WR_PH: begin
                cs_c = 1'b1; wn_c = 1'b0; addr_c = 3'd3; wdata_c = period_q[31:16];
                state_d = S_WR_CTL;
            end
            S_WR_CTL: begin
                cs_c = 1'b1; wn_c = 1'b0; addr_c = 3'd1; wdata_c = 16'h0007;
                running_d = 1'b1;
                tick_d    = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (cfg_stop_i) begin
                    state_d = S_STOP;
                end else if (cfg_start_i) begin
                    period_d = cfg_period_vld_i ? cfg_period_i : DEFAULT_PERIOD;
                    state_d  = S_WR_PL;
                end else if (tmr.irq && block_q == 2'd0) begin
                    state_d = S_ACK;
                end else if (snap_req_i) begin
                    state_d = S_SNAP_W;
                end
            end
            S_ACK: begin
                cs_c = 1'b1; wn_c = 1'b0; addr_c = 3'd0;
                tick_d  = tick_inc;
                // The irq level lags the status write; hold off re-entry until it drops.
                block_d = 2'd2;
                if (alarm_arm_i && tick_inc == alarm_tick_i) begin
                    hit_d     = 1'b1;
                    pending_d = 1'b1;
                end
                state_d = S_RUN;
            end
            S_STOP: begin
                cs_c = 1'b1; wn_c = 1'b0; addr_c = 3'd1; wdata_c = 16'h0008;
                running_d = 1'b0;
                state_d   = S_IDLE;
            end
            S_SNAP_W: begin
                cs_c = 1'b1; wn_c = 1'b0; addr_c = 3'd4;
                state_d = S_SNAP_RL;
            end
            S_SNAP_RL: begin
                cs_c = 1'b1; addr_c = 3'd4;
                state_d = S_SNAP_RH;
            end
            S_SNAP_RH: begin
                cs_c = 1'b1; addr_c = 3'd5;
                snap_lo_d = tmr.readdata;
                state_d   = S_SNAP_CAP;
            end
            S_SNAP_CAP: begin
                snap_value_d = {tmr.readdata, snap_lo_q};
                snap_valid_d = 1'b1;
                state_d      = running_q ? S_RUN : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tmr.address    = addr_c;
    assign tmr.chipselect = cs_c;
    assign tmr.write_n    = wn_c;
    assign tmr.writedata  = wdata_c;

    assign running_o       = running_q;
    assign busy_o          = (state_q != S_IDLE) && (state_q != S_RUN);
    assign tick_count_o    = tick_q;
    assign alarm_hit_o     = hit_q;
    assign alarm_pending_o = pending_q;
    assign snap_value_o    = snap_value_q;
    assign snap_valid_o    = snap_valid_q;

endmodule

// File: tb/tb_alarm_timer_sequencer.sv
// Directed bench: behavioural timer slaves, bus-write scoreboard, tick/alarm/snapshot checks.
module tb_alarm_timer_sequencer;

    typedef struct packed {
        logic [2:0]  a;
        logic [15:0] d;
        logic [31:0] c;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start, cfg_stop, cfg_vld;
    logic [31:0] cfg_period;
    logic [16:0] alarm_tick;
    logic        alarm_arm, alarm_ack, snap_req;
    logic        fire;
    logic [15:0] snap_lo, snap_hi;

    logic        running, busy, hit, pend, snapvld;
    logic [16:0] tick;
    logic [31:0] snapval;
    logic        running_w, busy_w, hit_w, pend_w, snapvld_w;
    logic [16:0] tick_w;
    logic [31:0] snapval_w;

    logic [31:0] cyc = 32'd0;
    wr_t         obs_q[$];
    wr_t         exp_q[$];
    wr_t         mon_w;
    int          rd_idx = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    int          exp_tick = 0;
    int          exp_tick_w = 0;
    logic [31:0] def_p = 32'd49999999;

    alarm_timer_sequencer_if tif ();
    alarm_timer_sequencer_if tifw ();

    alarm_timer_sequencer dut (
        .clk(clk), .rst(rst),
        .cfg_start_i(cfg_start), .cfg_stop_i(cfg_stop), .cfg_period_i(cfg_period),
        .cfg_period_vld_i(cfg_vld), .alarm_tick_i(alarm_tick), .alarm_arm_i(alarm_arm),
        .alarm_ack_i(alarm_ack), .snap_req_i(snap_req), .tmr(tif.master),
        .running_o(running), .busy_o(busy), .tick_count_o(tick), .alarm_hit_o(hit),
        .alarm_pending_o(pend), .snap_value_o(snapval), .snap_valid_o(snapvld)
    );

    alarm_timer_sequencer #(.TICK_WRAP(4)) dut_w (
        .clk(clk), .rst(rst),
        .cfg_start_i(cfg_start), .cfg_stop_i(cfg_stop), .cfg_period_i(cfg_period),
        .cfg_period_vld_i(cfg_vld), .alarm_tick_i(alarm_tick), .alarm_arm_i(alarm_arm),
        .alarm_ack_i(alarm_ack), .snap_req_i(snap_req), .tmr(tifw.master),
        .running_o(running_w), .busy_o(busy_w), .tick_count_o(tick_w), .alarm_hit_o(hit_w),
        .alarm_pending_o(pend_w), .snap_value_o(snapval_w), .snap_valid_o(snapvld_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // Timer models: irq level drops one cycle after the status write; readdata is registered.
    logic        irq_m, clr_m, irq_n, clr_n;
    logic [15:0] rd_m, rd_n;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_m <= 1'b0; clr_m <= 1'b0; rd_m <= 16'h0;
        end else begin
            clr_m <= tif.chipselect && !tif.write_n && tif.address == 3'd0;
            if (fire) irq_m <= 1'b1;
            else if (clr_m) irq_m <= 1'b0;
            rd_m <= (tif.chipselect && tif.write_n && tif.address == 3'd4) ? snap_lo :
                    (tif.chipselect && tif.write_n && tif.address == 3'd5) ? snap_hi : 16'h0;
        end
    end
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_n <= 1'b0; clr_n <= 1'b0; rd_n <= 16'h0;
        end else begin
            clr_n <= tifw.chipselect && !tifw.write_n && tifw.address == 3'd0;
            if (fire) irq_n <= 1'b1;
            else if (clr_n) irq_n <= 1'b0;
            rd_n <= (tifw.chipselect && tifw.write_n && tifw.address == 3'd4) ? snap_lo :
                    (tifw.chipselect && tifw.write_n && tifw.address == 3'd5) ? snap_hi : 16'h0;
        end
    end
    assign tif.irq       = irq_m;
    assign tif.readdata  = rd_m;
    assign tifw.irq      = irq_n;
    assign tifw.readdata = rd_n;

    always @(negedge clk) begin
        if (!rst && tif.chipselect && !tif.write_n) begin
            mon_w.a = tif.address;
            mon_w.d = tif.writedata;
            mon_w.c = cyc;
            obs_q.push_back(mon_w);
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
        n_assert++;
        assert (act === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, act, expv);
        end
    endtask

    task automatic push_exp(input logic [2:0] a, input logic [15:0] d);
        wr_t w;
        w.a = a; w.d = d; w.c = 32'd0;
        exp_q.push_back(w);
    endtask

    task automatic drain();
        wr_t e;
        repeat (3) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd_idx < obs_q.size()) begin
                chk("bus_wr", {45'd0, obs_q[rd_idx].a, obs_q[rd_idx].d}, {45'd0, e.a, e.d});
                rd_idx++;
            end else begin
                chk("bus_wr_missing", 64'(obs_q.size()), 64'(rd_idx + 1));
            end
        end
        chk("bus_wr_count", 64'(obs_q.size()), 64'(rd_idx));
        rd_idx = obs_q.size();
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input logic [31:0] p, input logic vld, output logic run_mid);
        logic [31:0] eff;
        eff = vld ? p : def_p;
        push_exp(3'd2, eff[15:0]);
        push_exp(3'd3, eff[31:16]);
        push_exp(3'd1, 16'h0007);
        cfg_period = p; cfg_vld = vld; cfg_start = 1'b1;
        cycle();
        cfg_start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        cycle();
        cycle();
        run_mid = running;
        cycle();
        chk("running_after_ctl", 64'(running), 64'd1);
        chk("busy_in_run", 64'(busy), 64'd0);
        chk("tick_restart", 64'(tick), 64'd0);
        chk("tick_w_restart", 64'(tick_w), 64'd0);
        exp_tick = 0;
        exp_tick_w = 0;
    endtask

    task automatic irq_once(input logic ack_at_hit, output int hits);
        hits = 0;
        push_exp(3'd0, 16'h0000);
        exp_tick   = (exp_tick == 86399) ? 0 : exp_tick + 1;
        exp_tick_w = (exp_tick_w == 3) ? 0 : exp_tick_w + 1;
        fire = 1'b1;
        cycle();
        fire = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (hit) hits++;
            alarm_ack = ack_at_hit && (k == 2);
            cycle();
        end
        alarm_ack = 1'b0;
        $display("irq: tick=%0d tick_w=%0d hits=%0d pending=%0b", tick, tick_w, hits, pend);
        chk("tick", 64'(tick), 64'(exp_tick));
        chk("tick_wrap", 64'(tick_w), 64'(exp_tick_w));
    endtask

    initial begin
        int          hits;
        int          b;
        int          exp_hits[4];
        logic        run_mid;
        logic        found;
        exp_hits = '{0, 0, 1, 0};

        rst = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_vld = 1'b0; cfg_period = 32'h0;
        alarm_tick = 17'd0; alarm_arm = 1'b0; alarm_ack = 1'b0; snap_req = 1'b0; fire = 1'b0;
        snap_lo = 16'h0; snap_hi = 16'h0;
        repeat (3) cycle();
        chk("rst_cs", 64'(tif.chipselect), 64'd0);
        chk("rst_write_n", 64'(tif.write_n), 64'd1);
        chk("rst_addr", 64'(tif.address), 64'd0);
        chk("rst_running", 64'(running), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tick", 64'(tick), 64'd0);
        chk("rst_alarm", 64'({hit, pend, snapvld}), 64'd0);
        chk("rst_snap", 64'(snapval), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle();

        // Programming sequence from IDLE, three back-to-back writes
        b = obs_q.size();
        restart(32'h0001_86A0, 1'b1, run_mid);
        $display("start: period=%h running_mid=%0b running=%0b", cfg_period, run_mid, running);
        chk("running_in_wr_ctl", 64'(run_mid), 64'd0);
        drain();
        chk("b2b_1", 64'(obs_q[b+1].c - obs_q[b].c), 64'd1);
        chk("b2b_2", 64'(obs_q[b+2].c - obs_q[b+1].c), 64'd1);

        // Restart while running, then five timeouts
        restart(32'd9, 1'b1, run_mid);
        for (int i = 0; i < 5; i++) irq_once(1'b0, hits);
        chk("tick_after_5", 64'(tick), 64'd5);
        drain();

        // Wrap behaviour over six timeouts
        restart(32'd9, 1'b1, run_mid);
        for (int i = 0; i < 6; i++) irq_once(1'b0, hits);
        drain();

        // Alarm at tick 3, held until acknowledged
        alarm_tick = 17'd3; alarm_arm = 1'b1;
        restart(32'd9, 1'b1, run_mid);
        for (int i = 0; i < 4; i++) begin
            irq_once(1'b0, hits);
            chk("alarm_hits", 64'(hits), 64'(exp_hits[i]));
        end
        chk("pending_held", 64'(pend), 64'd1);
        alarm_ack = 1'b1;
        cycle();
        alarm_ack = 1'b0;
        chk("pending_cleared", 64'(pend), 64'd0);
        drain();

        // Default period; ack coinciding with the hit leaves pending set
        alarm_tick = 17'd1;
        restart(32'h0, 1'b0, run_mid);
        irq_once(1'b1, hits);
        chk("hit_with_ack", 64'(hits), 64'd1);
        chk("pending_ack_same_cycle", 64'(pend), 64'd1);
        alarm_ack = 1'b1;
        cycle();
        alarm_ack = 1'b0;
        chk("pending_cleared_2", 64'(pend), 64'd0);
        alarm_arm = 1'b0;
        drain();

        // Snapshot with a timeout arriving mid-sequence
        snap_lo = 16'h1234; snap_hi = 16'h0005;
        push_exp(3'd4, 16'h0000);
        push_exp(3'd0, 16'h0000);
        exp_tick = exp_tick + 1;
        snap_req = 1'b1;
        cycle();
        snap_req = 1'b0;
        fire = 1'b1;
        cycle();
        fire = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (snapvld) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        $display("snap: valid=%0b value=%h", found, snapval);
        chk("snap_seen", 64'(found), 64'd1);
        chk("snap_value", 64'(snapval), 64'h0005_1234);
        chk("snap_value_w", 64'(snapval_w), 64'h0005_1234);
        cycle();
        chk("snap_valid_pulse", 64'(snapvld), 64'd0);
        repeat (8) cycle();
        chk("tick_after_snap_irq", 64'(tick), 64'(exp_tick));
        drain();

        // Stop in the same cycle as an irq
        push_exp(3'd1, 16'h0008);
        fire = 1'b1;
        cycle();
        fire = 1'b0;
        cfg_stop = 1'b1;
        cycle();
        cfg_stop = 1'b0;
        repeat (4) cycle();
        $display("stop: running=%0b busy=%0b tick=%0d", running, busy, tick);
        chk("stopped", 64'(running), 64'd0);
        chk("stop_idle", 64'(busy), 64'd0);
        chk("tick_held", 64'(tick), 64'(exp_tick));
        drain();

        // Reset asserted during the period-high write
        push_exp(3'd2, def_p[15:0]);
        cfg_vld = 1'b0;
        cfg_start = 1'b1;
        cycle();
        cfg_start = 1'b0;
        cycle();
        rst = 1'b1;
        #1;
        chk("midrst_cs", 64'(tif.chipselect), 64'd0);
        chk("midrst_write_n", 64'(tif.write_n), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_tick", 64'(tick), 64'd0);
        repeat (2) cycle();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) cycle();
        $display("midrst: busy=%0b running=%0b", busy, running);
        chk("midrst_idle", 64'(busy), 64'd0);
        chk("midrst_running", 64'(running), 64'd0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
